// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - beam codes, directions and FSM encoding for the parking sensor generator
package parking_pkg;

  localparam logic [1:0] BEAM_IDLE = 2'b00;
  localparam logic [1:0] BEAM_A    = 2'b10;
  localparam logic [1:0] BEAM_AB   = 2'b11;
  localparam logic [1:0] BEAM_B    = 2'b01;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_GAP
  } state_e;

  // Exit walks the enter pattern backwards, so P1/P3 swap with direction.
  function automatic logic [1:0] phase_code(input state_e st, input logic dir);
    logic [1:0] code;
    case (st)
      ST_P1:   code = (dir == DIR_EXIT) ? BEAM_B : BEAM_A;
      ST_P2:   code = BEAM_AB;
      ST_P3:   code = (dir == DIR_EXIT) ? BEAM_A : BEAM_B;
      default: code = BEAM_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - 8-bit loadable down-counter with zero flag for phase dwell timing
module phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 8'd0);

endmodule

// File: rtl/parking_sensor_gen.sv
// rtl/parking_sensor_gen.sv - two-beam car emulator driving enter/exit beam sequences
// Optional occupancy model and request rejection enabled by MODEL_CNT_EN.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int GAP      = 2,
  parameter int CAPACITY = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_dir,
  output logic       req_ready,
  output logic [1:0] btn,
  output logic       busy,
  output logic       done,
  output logic       req_err,
  output logic [2:0] occ
);

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP - 1);

  if (DWELL < 1 || DWELL > 255 || GAP < 1 || GAP > 255 || CAPACITY < 1 || CAPACITY > 7)
  begin : g_param_err
    $error("parking_sensor_gen: DWELL/GAP must be 1..255 and CAPACITY 1..7");
  end

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] btn_q, btn_d;
  logic       done_q, done_d;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero;
  logic       req_legal;

  phase_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    btn_d    = btn_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DWELL_LD;
    case (state_q)
      ST_IDLE: begin
        btn_d = BEAM_IDLE;
        if (req_valid) begin
          dir_d = req_dir;
          if (req_legal) begin
            state_d  = ST_P1;
            btn_d    = phase_code(ST_P1, req_dir);
            tmr_load = 1'b1;
          end
        end
      end
      ST_P1: begin
        if (tmr_zero) begin
          state_d  = ST_P2;
          btn_d    = phase_code(ST_P2, dir_q);
          tmr_load = 1'b1;
        end
      end
      ST_P2: begin
        if (tmr_zero) begin
          state_d  = ST_P3;
          btn_d    = phase_code(ST_P3, dir_q);
          tmr_load = 1'b1;
        end
      end
      ST_P3: begin
        if (tmr_zero) begin
          state_d  = ST_GAP;
          btn_d    = BEAM_IDLE;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          done_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        btn_d   = BEAM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_ENTER;
      btn_q   <= BEAM_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      btn_q   <= btn_d;
      done_q  <= done_d;
    end
  end

  assign btn       = btn_q;
  assign done      = done_q;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

`ifdef MODEL_CNT_EN
  localparam logic [2:0] CAP = 3'(CAPACITY);

  logic [2:0] occ_q, occ_d;
  logic       req_err_q, req_err_d;
  logic       accept;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign req_legal = (req_dir == DIR_ENTER) ? (occ_q != CAP) : (occ_q != 3'd0);

  // Legality was checked at accept, so the update below can never wrap.
  always_comb begin
    occ_d     = occ_q;
    req_err_d = accept && !req_legal;
    if (done_d) begin
      occ_d = (dir_q == DIR_EXIT) ? occ_q - 3'd1 : occ_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= 3'd0;
      req_err_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      req_err_q <= req_err_d;
    end
  end

  assign occ     = occ_q;
  assign req_err = req_err_q;
`else
  assign req_legal = 1'b1;
  assign occ       = 3'd0;
  assign req_err   = 1'b0;
`endif

endmodule

// File: tb/tb_parking_sensor_gen.sv
// tb/tb_parking_sensor_gen.sv - scoreboard bench for parking_sensor_gen (default or MODEL_CNT_EN build)
module tb_parking_sensor_gen;

  localparam int DWELL    = 4;
  localparam int GAP      = 2;
  localparam int CAPACITY = 7;
`ifdef MODEL_CNT_EN
  localparam bit MODEL = 1'b1;
`else
  localparam bit MODEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_dir;
  logic       req_ready;
  logic [1:0] btn;
  logic       busy;
  logic       done;
  logic       req_err;
  logic [2:0] occ;

  always #5 clk = ~clk;

  parking_sensor_gen #(
    .DWELL    (DWELL),
    .GAP      (GAP),
    .CAPACITY (CAPACITY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .btn       (btn),
    .busy      (busy),
    .done      (done),
    .req_err   (req_err),
    .occ       (occ)
  );

  typedef struct {
    logic [1:0] btn;
    logic       busy;
    logic       done;
    logic       ready;
    logic       err;
    logic [2:0] occ;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks    = 0;
  int   errors    = 0;
  int   m_occ     = 0;
  int   last_occ  = 0;
  int   exp_cnt   = 0;
  int   beam_cnt  = 0;
  int   gray_bad  = 0;
  logic [1:0] prev_btn = 2'b00;
  logic [5:0] hist     = 6'd0;
  logic       rst_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] b, input logic bs, input logic d,
                              input logic r, input logic er, input int o);
    exp_t x;
    x.btn = b; x.busy = bs; x.done = d; x.ready = r; x.err = er; x.occ = 3'(o);
    return x;
  endfunction

  // Expected cycles 1..15 after an accept edge for a sequence that runs.
  task automatic push_seq(input logic dir, input int o_old, input int o_new);
    logic [1:0] c1, c3;
    c1 = dir ? 2'b01 : 2'b10;
    c3 = dir ? 2'b10 : 2'b01;
    for (int n = 1; n <= 3*DWELL + GAP + 1; n++) begin
      if (n <= DWELL)                exp_q.push_back(mk(c1,    1, 0, 0, 0, o_old));
      else if (n <= 2*DWELL)         exp_q.push_back(mk(2'b11, 1, 0, 0, 0, o_old));
      else if (n <= 3*DWELL)         exp_q.push_back(mk(c3,    1, 0, 0, 0, o_old));
      else if (n == 3*DWELL + 1)     exp_q.push_back(mk(2'b00, 1, 1, 0, 0, o_new));
      else if (n <= 3*DWELL + GAP)   exp_q.push_back(mk(2'b00, 1, 0, 0, 0, o_new));
      else                           exp_q.push_back(mk(2'b00, 0, 0, 1, 0, o_new));
    end
  endtask

  task automatic send(input logic dir);
    int  w;
    bit  legal;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_dir   = dir;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    legal = !MODEL || (dir ? (m_occ != 0) : (m_occ != CAPACITY));
    @(posedge clk);
    last_occ = m_occ;
    if (legal) begin
      if (MODEL) m_occ = dir ? m_occ - 1 : m_occ + 1;
      exp_cnt = dir ? exp_cnt - 1 : exp_cnt + 1;
      push_seq(dir, last_occ, m_occ);
    end else begin
      exp_q.push_back(mk(2'b00, 0, 0, 1, 1, m_occ));
    end
    #1;
    req_valid = 1'b0;
    req_dir   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("btn",     btn,       e.btn);
      check("busy",    busy,      e.busy);
      check("done",    done,      e.done);
      check("ready",   req_ready, e.ready);
      check("req_err", req_err,   e.err);
      check("occ",     occ,       e.occ);
    end
    // Independent beam decoder: counts full enter/exit patterns and Gray steps.
    if (btn !== prev_btn) begin
      if (!rst_prev && $countones(btn ^ prev_btn) != 1) gray_bad++;
      if (btn == 2'b00) begin
        if (hist == 6'b10_11_01)      beam_cnt++;
        else if (hist == 6'b01_11_10) beam_cnt--;
        hist = 6'd0;
      end else begin
        hist = {hist[3:0], btn};
      end
    end
    prev_btn = btn;
    rst_prev = rst;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_dir   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_btn",   btn,       32'd0);
      check("rst_ready", req_ready, 32'd1);
      check("rst_busy",  busy,      32'd0);
      check("rst_done",  done,      32'd0);
      check("rst_err",   req_err,   32'd0);
      check("rst_occ",   occ,       32'd0);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;

    send(1'b1);
    drain();
    send(1'b0);
    drain();
    send(1'b0);
    send(1'b1);
    drain();

    send(1'b0);
    repeat (DWELL + 1) @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(mk(2'b11, 1, 0, 0, 0, last_occ));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_occ   = 0;
    exp_cnt = exp_cnt - 1;
    repeat (4) exp_q.push_back(mk(2'b00, 0, 0, 1, 0, 0));
    drain();

    send(1'b0);
    drain();

`ifdef MODEL_CNT_EN
    repeat (CAPACITY) send(1'b0);
    drain();
    check("occ_full", occ, CAPACITY);
    send(1'b0);
    drain();
    repeat (CAPACITY) send(1'b1);
    drain();
    send(1'b1);
    drain();
`endif

    @(posedge clk); #1;
    check("beam_cnt", beam_cnt, exp_cnt);
    check("gray",     gray_bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
